reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 25 ++
 rtl/reset_sequencer_timer.sv | 47 ++++
 rtl/reset_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, stage
// indices and counter sizing.
package reset_seq_pkg;

  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] STG_SDRAM = 3'd0;
  localparam logic [IDX_W-1:0] STG_SCCB  = 3'd1;
  localparam logic [IDX_W-1:0] STG_LCD   = 3'd2;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    SETTLE,
    RELEASE,
    RUN,
    SHUTDOWN,
    FAULT
  } seq_state_e;

  // Width able to hold n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_timer.sv
// Loadable saturating down-counter. done_o pulses for one cycle when a loaded
// count has run down to zero; the counter then rests at zero.
module seq_timer
  import reset_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             armed_q, armed_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    count_d = count_q;
    armed_d = armed_q;
    if (load_i) begin
      count_d = load_val_i;
      armed_d = 1'b1;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      armed_d = 1'b0;
    end
  end

  assign done_o = armed_q && (count_q == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement or process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      armed_q <= 1'b0;
    end else begin
      count_q <= count_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets one stage at a time after PLL lock, and
// re-asserts them in reverse order on lock loss or a software restart.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int SETTLE_CNT  = 16,
  parameter int TIMEOUT_CNT = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_ready,
  output logic                  seq_fault,
  output logic [2:0]            fault_stage
);

  localparam int SET_W = cnt_width(SETTLE_CNT);
  localparam int TO_W  = cnt_width(TIMEOUT_CNT);

  localparam logic [SET_W-1:0]      SET_RELOAD = SET_W'(SETTLE_CNT - 1);
  localparam logic [TO_W-1:0]       TO_RELOAD  = TO_W'(TIMEOUT_CNT - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE  = NUM_STAGES'(1);

  seq_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0]  stage_rst_n_q, stage_rst_n_d;
  logic                   seq_ready_q, seq_ready_d;
  logic                   seq_fault_q, seq_fault_d;
  logic [2:0]             fault_stage_q, fault_stage_d;

  logic settle_load, settle_done;
  logic to_load, to_done;
  logic done_sel, abort, all_done;

  seq_timer #(.WIDTH(SET_W)) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (settle_load),
    .load_val_i (SET_RELOAD),
    .done_o     (settle_done)
  );

  seq_timer #(.WIDTH(TO_W)) u_timeout_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (to_load),
    .load_val_i (TO_RELOAD),
    .done_o     (to_done)
  );

  always_comb begin
    done_sel = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx_q == IDX_W'(i)) done_sel = stage_done[i];
    end
  end

  assign abort    = !locked || sw_rst_req;
  assign all_done = &stage_done;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    stage_rst_n_d = stage_rst_n_q;
    seq_ready_d   = 1'b0;
    seq_fault_d   = seq_fault_q;
    fault_stage_d = fault_stage_q;
    settle_load   = 1'b0;
    to_load       = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        idx_d         = STG_SDRAM;
        stage_rst_n_d = '0;
        if (locked) begin
          state_d     = SETTLE;
          settle_load = 1'b1;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_d     = SHUTDOWN;
          settle_load = 1'b1;
        end else if (settle_done) begin
          // Released stages stay a contiguous block from bit 0, so releasing
          // the next one is a shift-in of a 1.
          state_d       = RELEASE;
          stage_rst_n_d = (stage_rst_n_q << 1) | STAGE_ONE;
          to_load       = 1'b1;
        end
      end

      RELEASE: begin
        if (abort) begin
          state_d     = SHUTDOWN;
          settle_load = 1'b1;
        end else if (done_sel) begin
          if (idx_q == LAST_IDX) begin
            state_d     = RUN;
            seq_ready_d = all_done;
          end else begin
            idx_d       = idx_q + IDX_W'(1);
            state_d     = SETTLE;
            settle_load = 1'b1;
          end
        end else if (to_done) begin
          state_d       = FAULT;
          stage_rst_n_d = '0;
          seq_fault_d   = 1'b1;
          fault_stage_d = idx_q;
        end
      end

      RUN: begin
        if (abort) begin
          state_d     = SHUTDOWN;
          settle_load = 1'b1;
        end else begin
          seq_ready_d = all_done;
        end
      end

      SHUTDOWN: begin
        // Lock and restart requests are ignored until every reset is back on.
        if (settle_done) begin
          stage_rst_n_d = stage_rst_n_q >> 1;
          if ((stage_rst_n_q >> 1) == '0) begin
            state_d = WAIT_LOCK;
            idx_d   = STG_SDRAM;
          end else begin
            settle_load = 1'b1;
          end
        end
      end

      FAULT: begin
        stage_rst_n_d = '0;
        if (sw_rst_req) begin
          state_d       = WAIT_LOCK;
          idx_d         = STG_SDRAM;
          seq_fault_d   = 1'b0;
          fault_stage_d = '0;
        end
      end

      default: begin
        state_d       = WAIT_LOCK;
        stage_rst_n_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_LOCK;
      idx_q         <= STG_SDRAM;
      stage_rst_n_q <= '0;
      seq_ready_q   <= 1'b0;
      seq_fault_q   <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      stage_rst_n_q <= stage_rst_n_d;
      seq_ready_q   <= seq_ready_d;
      seq_fault_q   <= seq_fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  assign stage_rst_n = stage_rst_n_q;
  assign seq_ready   = seq_ready_q;
  assign seq_fault   = seq_fault_q;
  assign fault_stage = fault_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed bring-up/shutdown/fault scenarios with
// literal timings, then random traffic compared every cycle to a model.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int N      = 3;
  localparam int SETTLE = 4;
  localparam int TMO    = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         locked = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic [N-1:0] stage_done = '0;
  logic [N-1:0] stage_rst_n;
  logic         seq_ready;
  logic         seq_fault;
  logic [2:0]   fault_stage;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES  (N),
    .SETTLE_CNT  (SETTLE),
    .TIMEOUT_CNT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .locked      (locked),
    .sw_rst_req  (sw_rst_req),
    .stage_done  (stage_done),
    .stage_rst_n (stage_rst_n),
    .seq_ready   (seq_ready),
    .seq_fault   (seq_fault),
    .fault_stage (fault_stage)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phases described by how many stages are released and
  // how long the current wait has lasted, counted upward in cycles.
  localparam int MD_IDLE = 0;
  localparam int MD_GAP  = 1;
  localparam int MD_WAIT = 2;
  localparam int MD_UP   = 3;
  localparam int MD_DOWN = 4;
  localparam int MD_ERR  = 5;

  typedef struct packed {
    int mode;
    int nrel;
    int stg;
    int el;
    int fs;
    bit rdy;
    bit flt;
  } model_t;

  model_t m = '0;

  function automatic model_t model_step(input model_t s, input logic r, input logic lk,
                                        input logic rq, input logic [N-1:0] dn);
    model_t n;
    bit     abrt;
    bit     cur_done;
    int     dv;
    n        = s;
    n.rdy    = 1'b0;
    abrt     = !lk || rq;
    dv       = int'(dn);
    cur_done = ((dv >> s.stg) & 1) == 1;
    if (r) begin
      n = '0;
    end else begin
      case (s.mode)
        MD_IDLE: if (lk) begin n.mode = MD_GAP; n.el = 0; end
        MD_GAP: begin
          if (abrt) begin n.mode = MD_DOWN; n.el = 0; end
          else if (s.el == SETTLE - 1) begin n.mode = MD_WAIT; n.nrel = s.stg + 1; n.el = 0; end
          else n.el = s.el + 1;
        end
        MD_WAIT: begin
          if (abrt) begin n.mode = MD_DOWN; n.el = 0; end
          else if (cur_done) begin
            if (s.stg == N - 1) begin n.mode = MD_UP; n.rdy = (dv == (1 << N) - 1); end
            else begin n.stg = s.stg + 1; n.mode = MD_GAP; n.el = 0; end
          end else if (s.el == TMO - 1) begin
            n.mode = MD_ERR; n.nrel = 0; n.flt = 1'b1; n.fs = s.stg;
          end else n.el = s.el + 1;
        end
        MD_UP: begin
          if (abrt) begin n.mode = MD_DOWN; n.el = 0; end
          else n.rdy = (dv == (1 << N) - 1);
        end
        MD_DOWN: begin
          if (s.el == SETTLE - 1) begin
            n.el = 0;
            if (s.nrel > 0) n.nrel = s.nrel - 1;
            if (s.nrel <= 1) begin n.mode = MD_IDLE; n.stg = 0; end
          end else n.el = s.el + 1;
        end
        MD_ERR: if (rq) begin n.mode = MD_IDLE; n.flt = 1'b0; n.fs = 0; n.stg = 0; end
        default: n = '0;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m, rst, locked, sw_rst_req, stage_done);

  function automatic logic [N-1:0] released_mask(input int nrel);
    return N'((1 << nrel) - 1);
  endfunction

  function automatic bit contiguous(input logic [N-1:0] v);
    logic [N:0] w;
    w = {1'b0, v};
    return ((w + (N+1)'(1)) & w) == '0;
  endfunction

  bit compare_on = 1'b0;

  initial begin
    wait (compare_on);
    forever begin
      @(negedge clk);
      check("cyc_stage_rst_n", 32'(stage_rst_n), 32'(released_mask(m.nrel)));
      check("cyc_seq_ready",   32'(seq_ready),   32'(m.rdy));
      check("cyc_seq_fault",   32'(seq_fault),   32'(m.flt));
      check("cyc_fault_stage", 32'(fault_stage), 32'(m.fs));
      check("cyc_contiguous",  32'(contiguous(stage_rst_n)), 32'd1);
    end
  end

  // Stage responder: stage i reports done dly[i] cycles after its release.
  int           dly[N] = '{20, 20, 20};
  int           cnt[N] = '{0, 0, 0};
  bit           rand_dly = 1'b0;
  logic [N-1:0] kill = '0;

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 99 + $urandom_range(0, 2);
    if (r == 1) return 1_000_000;
    return $urandom_range(1, 30);
  endfunction

  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (stage_rst_n[i] === 1'b1) begin
        if (cnt[i] == 0 && rand_dly) dly[i] = pick_delay();
        if (cnt[i] < 2_000_000) cnt[i]++;
      end else begin
        cnt[i] = 0;
      end
      stage_done[i] = (stage_rst_n[i] === 1'b1) && (cnt[i] >= dly[i]) && !kill[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rst(input logic [N-1:0] val, input int budget, output int n);
    n = 0;
    while (stage_rst_n !== val && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_fault(input int budget, output int n);
    n = 0;
    while (seq_fault !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int lock_down;
    lock_down = 0;

    // Reset state
    tick();
    tick();
    compare_on = 1'b1;
    check("rst_stage_rst_n", 32'(stage_rst_n), 32'd0);
    check("rst_seq_ready",   32'(seq_ready),   32'd0);
    check("rst_seq_fault",   32'(seq_fault),   32'd0);
    check("rst_fault_stage", 32'(fault_stage), 32'd0);

    // Normal bring-up, lock at cycle 10
    rst = 1'b0;
    repeat (9) tick();
    check("s1_no_lock_hold", 32'(stage_rst_n), 32'd0);
    locked = 1'b1;
    repeat (4) tick();
    check("s1_settle_hold", 32'(stage_rst_n), 32'd0);
    tick();
    check("s1_release0", 32'(stage_rst_n), 32'b001);
    wait_rst(3'b011, 60, n);
    check("s1_release1_latency", 32'(n), 32'd24);
    wait_rst(3'b111, 60, n);
    check("s1_release2_latency", 32'(n), 32'd24);
    repeat (19) tick();
    check("s1_ready_early", 32'(seq_ready), 32'd0);
    tick();
    check("s1_ready", 32'(seq_ready), 32'd1);

    // One-cycle lock loss in RUN
    locked = 1'b0;
    tick();
    locked = 1'b1;
    check("s2_ready_drop", 32'(seq_ready), 32'd0);
    check("s2_rst_hold", 32'(stage_rst_n), 32'b111);
    wait_rst(3'b011, 20, n);
    check("s2_down_to_011", 32'(n), 32'd4);
    wait_rst(3'b001, 20, n);
    check("s2_down_to_001", 32'(n), 32'd4);
    wait_rst(3'b000, 20, n);
    check("s2_down_to_000", 32'(n), 32'd4);
    wait_rst(3'b001, 20, n);
    check("s2_restart", 32'(n), 32'd5);
    wait_rst(3'b111, 100, n);
    repeat (20) tick();
    check("s2_ready_again", 32'(seq_ready), 32'd1);

    // Synchronous reset in RUN; stage 0 will meet its timeout exactly on the tie
    dly[0] = TMO;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_rst_n",   32'(stage_rst_n), 32'd0);
    check("s6_ready",   32'(seq_ready),   32'd0);
    check("s6_fault",   32'(seq_fault),   32'd0);
    check("s6_fstage",  32'(fault_stage), 32'd0);

    // Done on the last timeout cycle wins
    wait_rst(3'b001, 20, n);
    check("s4_release0", 32'(n), 32'd5);
    wait_rst(3'b011, 200, n);
    check("s4_tie_release1", 32'(n), 32'd104);
    check("s4_no_fault", 32'(seq_fault), 32'd0);
    dly[0] = 20;
    wait_rst(3'b111, 60, n);
    check("s4_release2", 32'(n), 32'd24);
    repeat (20) tick();
    check("s4_ready", 32'(seq_ready), 32'd1);

    // Timeout on stage 1
    dly[1] = 1_000_000;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("s3_req_ready_drop", 32'(seq_ready), 32'd0);
    wait_rst(3'b000, 40, n);
    check("s3_full_shutdown", 32'(n), 32'd12);
    wait_rst(3'b001, 20, n);
    check("s3_restart0", 32'(n), 32'd5);
    wait_rst(3'b011, 60, n);
    check("s3_release1", 32'(n), 32'd24);
    wait_fault(200, n);
    check("s3_fault_latency", 32'(n), 32'd100);
    check("s3_fault_rst_n", 32'(stage_rst_n), 32'd0);
    check("s3_fault_stage", 32'(fault_stage), 32'(STG_SCCB));
    locked = 1'b0;
    repeat (3) tick();
    locked = 1'b1;
    repeat (3) tick();
    check("s3_lock_ignored_fault", 32'(seq_fault), 32'd1);
    check("s3_lock_ignored_rst_n", 32'(stage_rst_n), 32'd0);
    dly[1] = 60;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("s3_clear_fault", 32'(seq_fault), 32'd0);
    check("s3_clear_stage", 32'(fault_stage), 32'd0);
    wait_rst(3'b001, 20, n);
    check("s3_restart", 32'(n), 32'd5);

    // Software restart while releasing stage 1
    wait_rst(3'b011, 60, n);
    check("s5_release1", 32'(n), 32'd24);
    repeat (10) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    wait_rst(3'b001, 20, n);
    check("s5_down_to_001", 32'(n), 32'd4);
    wait_rst(3'b000, 20, n);
    check("s5_down_to_000", 32'(n), 32'd4);
    wait_rst(3'b001, 20, n);
    check("s5_restart", 32'(n), 32'd5);

    // Random traffic against the model
    rand_dly = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if (lock_down > 0) begin
        lock_down--;
        if (lock_down == 0) locked = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        locked    = 1'b0;
        lock_down = $urandom_range(1, 20);
      end
      sw_rst_req = ($urandom_range(0, 149) == 0);
      rst        = ($urandom_range(0, 1499) == 0);
      kill       = ($urandom_range(0, 99) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      tick();
    end
    rst        = 1'b0;
    sw_rst_req = 1'b0;
    locked     = 1'b1;
    kill       = '0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
